// File: rtl/axi_pkg.sv
// Shared AXI types for the burst master: channel widths, burst/response codes
// and the master state encoding.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif

package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_W    = 3'd4,
      ST_B    = 3'd5
   } mst_state_e;

   // Response codes are ordered by severity, so "worst" is a plain maximum.
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 initiator: turns one core memory request into one
// INCR read or write burst and reports completion with the worst response.
//
// state | meaning
// IDLE  | waiting for a core request (req_ready=1)
// AR    | read address presented, waiting for ARREADY
// R     | accepting read beats until RLAST
// AW    | write address presented, waiting for AWREADY
// W     | forwarding core write beats, WLAST on the len-th beat
// B     | waiting for the write response
module axi_burst_master
   import axi_pkg::*;
#(
   parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [`AXI_ADDR_BITS-1:0]   req_addr,
   input  logic [`AXI_LEN_BITS-1:0]    req_len,
   input  logic [`AXI_SIZE_BITS-1:0]   req_size,
   input  logic                        wd_valid,
   output logic                        wd_ready,
   input  logic [`AXI_DATA_BITS-1:0]   wd_data,
   input  logic [`AXI_STRB_BITS-1:0]   wd_strb,
   output logic                        rd_valid,
   output logic [`AXI_DATA_BITS-1:0]   rd_data,
   output logic                        rd_last,
   output logic                        done,
   output logic [1:0]                  done_resp,
   output logic [`AXI_ID_BITS-1:0]     ARID,
   output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
   output logic [`AXI_LEN_BITS-1:0]    ARLEN,
   output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
   output logic [1:0]                  ARBURST,
   output logic                        ARVALID,
   input  logic                        ARREADY,
   input  logic [`AXI_ID_BITS-1:0]     RID,
   input  logic [`AXI_DATA_BITS-1:0]   RDATA,
   input  logic [1:0]                  RRESP,
   input  logic                        RLAST,
   input  logic                        RVALID,
   output logic                        RREADY,
   output logic [`AXI_ID_BITS-1:0]     AWID,
   output logic [`AXI_ADDR_BITS-1:0]   AWADDR,
   output logic [`AXI_LEN_BITS-1:0]    AWLEN,
   output logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
   output logic [1:0]                  AWBURST,
   output logic                        AWVALID,
   input  logic                        AWREADY,
   output logic [`AXI_DATA_BITS-1:0]   WDATA,
   output logic [`AXI_STRB_BITS-1:0]   WSTRB,
   output logic                        WLAST,
   output logic                        WVALID,
   input  logic                        WREADY,
   input  logic [`AXI_ID_BITS-1:0]     BID,
   input  logic [1:0]                  BRESP,
   input  logic                        BVALID,
   output logic                        BREADY
);

   mst_state_e                 state_q, state_d;
   logic [`AXI_ADDR_BITS-1:0]  addr_q, addr_d;
   logic [`AXI_LEN_BITS-1:0]   len_q, len_d;
   logic [`AXI_SIZE_BITS-1:0]  size_q, size_d;
   logic [`AXI_LEN_BITS-1:0]   cnt_q, cnt_d;
   logic [1:0]                 resp_q, resp_d;
   logic                       last_beat;
   logic                       unused_ids;

   assign unused_ids = ^{RID, BID};
   assign last_beat  = (cnt_q == len_q);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      cnt_d     = cnt_q;
      resp_d    = resp_q;
      done      = 1'b0;
      done_resp = RESP_OKAY;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               len_d   = req_len;
               size_d  = req_size;
               cnt_d   = '0;
               resp_d  = RESP_OKAY;
               state_d = req_write ? ST_AW : ST_AR;
            end
         end
         ST_AR: if (ARREADY) state_d = ST_R;
         ST_R: begin
            if (RVALID) begin
               cnt_d  = cnt_q + 1'b1;
               resp_d = resp_max(resp_q, RRESP);
               if (RLAST) begin
                  state_d   = ST_IDLE;
                  done      = 1'b1;
                  // A slave ending the burst early (or late) is reported as an error.
                  done_resp = last_beat ? resp_max(resp_q, RRESP) : RESP_SLVERR;
               end
            end
         end
         ST_AW: if (AWREADY) state_d = ST_W;
         ST_W: begin
            if (wd_valid && WREADY) begin
               cnt_d = cnt_q + 1'b1;
               if (last_beat) state_d = ST_B;
            end
         end
         ST_B: begin
            if (BVALID) begin
               state_d   = ST_IDLE;
               done      = 1'b1;
               done_resp = resp_max(BRESP, resp_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // req_ready is masked by reset so the core never sees an accept during reset.
   assign req_ready = (state_q == ST_IDLE) && ARESETn;

   assign ARID    = MASTER_ID;
   assign ARADDR  = addr_q;
   assign ARLEN   = len_q;
   assign ARSIZE  = size_q;
   assign ARBURST = BURST_INCR;
   assign ARVALID = (state_q == ST_AR);

   assign RREADY   = (state_q == ST_R);
   assign rd_valid = (state_q == ST_R) && RVALID;
   assign rd_data  = RDATA;
   assign rd_last  = (state_q == ST_R) && RLAST;

   assign AWID    = MASTER_ID;
   assign AWADDR  = addr_q;
   assign AWLEN   = len_q;
   assign AWSIZE  = size_q;
   assign AWBURST = BURST_INCR;
   assign AWVALID = (state_q == ST_AW);

   assign WVALID   = (state_q == ST_W) && wd_valid;
   assign wd_ready = (state_q == ST_W) && WREADY;
   assign WDATA    = wd_data;
   assign WSTRB    = wd_strb;
   assign WLAST    = (state_q == ST_W) && last_beat;

   assign BREADY = (state_q == ST_B);

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 initiator that turns a simple single-request memory port (from a cache or DMA front-end) into AXI INCR read or write bursts.
- It is the master-side counterpart of the SRAM slave wrapper and connects to one master port of the AXI interconnect.
- Only one transaction is outstanding at a time: no interleaving, no out-of-order completion.

Parameters:
MASTER_ID, 0, value driven on ARID/AWID (`AXI_ID_BITS wide)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  request accepted (IDLE only)
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  `AXI_ADDR_BITS  burst start address (size-aligned)
req_len  in  `AXI_LEN_BITS  beats minus 1
req_size  in  `AXI_SIZE_BITS  bytes per beat = 1<<size
wd_valid / wd_ready  in/out  1  core write-data beat handshake
wd_data  in  `AXI_DATA_BITS  write beat data
wd_strb  in  `AXI_STRB_BITS  write beat strobes
rd_valid  out  1  read beat valid (core always accepts)
rd_data  out  `AXI_DATA_BITS  read beat data
rd_last  out  1  final read beat
done  out  1  one-cycle pulse: transaction complete
done_resp  out  2  worst response of the transaction
AR*/R*/AW*/W*/B*  AXI4 master channels, standard widths (ARID/AWID `AXI_ID_BITS; RID/BID inputs ignored)

Behaviour:
- Reset (async): state IDLE. All AXI VALIDs 0, RREADY 0, BREADY 0. req_ready 0 while in reset. done 0, done_resp 0, all address/len/size registers 0. Reset mid-burst abandons the transaction immediately, with no completion.
- States: IDLE, AR, R, AW, W, B.
- IDLE: req_ready=1. On req_valid, latch addr/len/size/write, clear beat counter and resp. Next state is AW if write, else AR.
- AR: ARVALID=1, with ARADDR/ARLEN/ARSIZE from registers, ARBURST=INCR (2'b01) and ARID=MASTER_ID. These must stay stable until ARREADY. Handshake moves to R.
- R: RREADY=1. rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST (combinational pass-through). Each beat increments the counter and ORs in the worse response (max of RRESP). A beat with RVALID&RLAST goes to IDLE with done=1 in the same cycle. If RLAST arrives with counter≠len, done_resp is forced to SLVERR (2'b10).
- AW: AWVALID with the same stability rule as AR. Handshake moves to W. W is never asserted before the AW handshake.
- W: WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB pass through. WLAST = (counter==len). Each WVALID&WREADY increments the counter. The last beat moves to B. The core must hold wd_* stable until wd_ready.
- B: BREADY=1. BVALID moves to IDLE, done=1, done_resp=max(BRESP, stored resp).
- VALID never depends on READY (no combinational READY→VALID path). A request during non-IDLE states sees req_ready=0.
- Counter is `AXI_LEN_BITS wide: max 16 beats, no wrap needed.
- Addresses are not incremented locally; the slave computes beat addresses.
- Latency: request accept → ARVALID next cycle. Minimum read of N beats = 2+N cycles.

Decomposition:
- Shared package axi_pkg: burst enum (FIXED/INCR/WRAP), resp codes OKAY/EXOKAY/SLVERR/DECERR, master state enum.
- Widths come from the existing AXI_define macros.
- No sub-module; single FSM plus beat counter.

Test Plan:
- Single read: req addr 0x1000, len 0, size 2, ARREADY immediate, RDATA 0xDEADBEEF RLAST=1. Expect ARVALID for 1 cycle, rd_data=0xDEADBEEF, rd_last=1, done=1, done_resp=0.
- Stalled AR: slave holds ARREADY low 3 cycles. Expect ARVALID held high, ARADDR=0x2000 and ARLEN=3 stable. Then 4 beats 0..3 with RLAST on the 4th; done after beat 4.
- Write burst: len 1, wd beats 0x11111111/strb 0xF and 0x22220000/strb 0xC, WREADY toggling. Expect WLAST only on beat 2, AW handshake before any WVALID, done with OKAY.
- Error response: write with BRESP=2'b10. Expect done_resp=2'b10. Separately, RLAST on beat 2 of a len-3 read → done_resp=2'b10.
- Back-pressure: req_valid held during a read. Expect req_ready=0 until IDLE, then second request accepted the cycle after done.
- Reset mid-write: ARESETn low during W beat 1. Expect all VALIDs 0 asynchronously, state IDLE, no done pulse. A fresh read after reset completes normally.
